// File: rtl/rv32i_mc_core.sv
// Multi-cycle RV32I/RV32E core with valid/ready instruction and data ports.
// It halts on a configurable halt word and traps on illegal instructions. It also has a debug register read port.
module rv32i_mc_core #(
    parameter logic [31:0] RESET_PC   = 32'h80000000,
    parameter logic [31:0] HALT_INSTR = 32'hdead10cc,
    parameter int          NREGS      = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  dmem_op,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata,
    output logic [31:0] dbg_pc,
    output logic        wb,
    output logic        done,
    output logic        trap
);
    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state;
    logic [31:0] regs [NREGS];
    logic [31:0] pc, ir, rs1_val, rs2_val, imm, result, next_pc;
    logic        trap_q;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [AW-1:0] rd_idx;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign rd_idx = rd[AW-1:0];

    // Decode: legality, register usage and immediate format.
    logic        legal, uses_rd, uses_rs1, uses_rs2, illegal;
    logic [31:0] imm_dec;

    always_comb begin
        legal    = 1'b0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        imm_dec  = {{20{ir[31]}}, ir[31:20]};
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                legal = 1'b1; uses_rd = 1'b1; imm_dec = {ir[31:12], 12'b0};
            end
            OP_JAL: begin
                legal = 1'b1; uses_rd = 1'b1;
                imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OP_JALR: begin
                legal = (funct3 == 3'b000); uses_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OP_LOAD: begin
                legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                uses_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                legal = (funct3 <= 3'b010); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OP_IMM: begin
                legal = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                        (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
                uses_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OP_REG: begin
                legal = (funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        illegal = !legal || ((NREGS < 32) &&
                  ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4])));
    end

    // Execute: ALU, branch compare, result and next-PC selection.
    logic [31:0] op_b, sum, alu_out, exec_result, exec_next;
    logic        alt, taken;

    always_comb begin
        op_b = (opcode == OP_REG) ? rs2_val : imm;
        alt  = ir[30] && (opcode == OP_REG || funct3 == 3'b101);
        sum  = rs1_val + imm;
        case (funct3)
            3'b000:  alu_out = alt ? rs1_val - op_b : rs1_val + op_b;
            3'b001:  alu_out = rs1_val << op_b[4:0];
            3'b010:  alu_out = {31'b0, $signed(rs1_val) < $signed(op_b)};
            3'b011:  alu_out = {31'b0, rs1_val < op_b};
            3'b100:  alu_out = rs1_val ^ op_b;
            3'b101:  alu_out = alt ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
            3'b110:  alu_out = rs1_val | op_b;
            default: alu_out = rs1_val & op_b;
        endcase
        case (funct3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val < rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
        exec_next = pc + 32'd4;
        case (opcode)
            OP_LUI:             exec_result = imm;
            OP_AUIPC:           exec_result = pc + imm;
            OP_JAL, OP_JALR:    exec_result = pc + 32'd4;
            OP_LOAD, OP_STORE:  exec_result = sum;
            default:            exec_result = alu_out;
        endcase
        if (opcode == OP_JAL || (opcode == OP_BRANCH && taken)) exec_next = pc + imm;
        else if (opcode == OP_JALR)                             exec_next = sum & ~32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            rs1_val <= '0;
            rs2_val <= '0;
            imm     <= '0;
            result  <= '0;
            next_pc <= '0;
            trap_q  <= 1'b0;
            // NOTE: the register file must come up zeroed, so it is built from resettable flops rather than a RAM.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (imem_ready) begin
                    if (imem_rdata == HALT_INSTR) state <= S_HALT;
                    else begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: if (illegal) begin
                    trap_q <= 1'b1;
                    state  <= S_HALT;
                end else begin
                    rs1_val <= regs[rs1[AW-1:0]];
                    rs2_val <= regs[rs2[AW-1:0]];
                    imm     <= imm_dec;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    result  <= exec_result;
                    next_pc <= exec_next;
                    state   <= (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_WB;
                end
                S_MEM: if (dmem_ready) begin
                    if (opcode == OP_LOAD) result <= dmem_rdata;
                    state <= S_WB;
                end
                S_WB: begin
                    if (uses_rd && rd_idx != '0) regs[rd_idx] <= result;
                    pc    <= next_pc;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Requests are decoded from state; the reset term keeps imem_req low while rst is held.
    assign imem_req   = (state == S_FETCH) && !rst;
    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = dmem_req && (opcode == OP_STORE);
    assign dmem_op    = dmem_req ? funct3 : 3'b000;
    assign dmem_addr  = dmem_req ? result : 32'd0;
    assign dmem_wdata = dmem_req ? rs2_val : 32'd0;
    assign wb         = (state == S_WB);
    assign dbg_pc     = wb ? pc : 32'd0;
    assign done       = (state == S_HALT);
    assign trap       = trap_q;
    assign dbg_rdata  = (dbg_raddr == 5'd0 || 32'(dbg_raddr) >= 32'(NREGS)) ? 32'd0
                                                                             : regs[dbg_raddr[AW-1:0]];
endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: RV32I program, halt, branch/jump, stalled load, async reset,
// and an RV32E instance that traps on an out-of-range register.
module tb_rv32i_mc_core;
    logic        clk, rst, rst_e;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, wb, done, trap;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, dbg_rdata, dbg_pc;
    logic [2:0]  dmem_op;
    logic [4:0]  dbg_raddr, dbg_raddr_e;
    logic        imem_req_e, imem_ready_e, dmem_req_e, dmem_we_e, wb_e, done_e, trap_e;
    logic [31:0] imem_addr_e, imem_rdata_e, dmem_addr_e, dmem_wdata_e, dbg_rdata_e, dbg_pc_e;
    logic [2:0]  dmem_op_e;

    logic [31:0] imem [128];
    logic [31:0] imem_e [4];
    logic [31:0] dmem [16];
    int          ld_delay, dcnt, cyc;
    int          errors = 0, checks = 0;
    int          ireq_cnt = 0, ld_req_cnt = 0, ld_bad = 0, wb_e_cnt = 0;
    logic [31:0] wb_pc_q [$];
    int          wb_cyc_q [$];

    logic [31:0] exp_pc [9] = '{32'h80000000, 32'h80000004, 32'h80000008, 32'h8000000C,
                                32'h80000010, 32'h80000018, 32'h8000001C, 32'h80000020,
                                32'h80000024};
    int          exp_cyc [9] = '{3, 7, 12, 20, 24, 28, 32, 36, 40};

    rv32i_mc_core u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_op(dmem_op), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .dbg_pc(dbg_pc),
        .wb(wb), .done(done), .trap(trap)
    );

    rv32i_mc_core #(.NREGS(16)) u_dut_e (
        .clk(clk), .rst(rst_e),
        .imem_req(imem_req_e), .imem_addr(imem_addr_e), .imem_ready(imem_ready_e),
        .imem_rdata(imem_rdata_e),
        .dmem_req(dmem_req_e), .dmem_we(dmem_we_e), .dmem_op(dmem_op_e), .dmem_addr(dmem_addr_e),
        .dmem_wdata(dmem_wdata_e), .dmem_ready(1'b0), .dmem_rdata(32'd0),
        .dbg_raddr(dbg_raddr_e), .dbg_rdata(dbg_rdata_e), .dbg_pc(dbg_pc_e),
        .wb(wb_e), .done(done_e), .trap(trap_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait instruction memories; data memory stalls loads by ld_delay cycles.
    assign imem_ready   = imem_req;
    assign imem_rdata   = imem[imem_addr[8:2]];
    assign imem_ready_e = imem_req_e;
    assign imem_rdata_e = imem_e[imem_addr_e[3:2]];
    assign dmem_ready   = dmem_req && (dcnt == (dmem_we ? 0 : ld_delay));
    assign dmem_rdata   = dmem[dmem_addr[5:2]];

    always @(posedge clk) begin
        dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[5:2]] <= dmem_wdata;
    end

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wb) begin
            wb_pc_q.push_back(dbg_pc);
            wb_cyc_q.push_back(cyc);
        end
        if (imem_req) ireq_cnt++;
        if (dmem_req && !dmem_we) begin
            ld_req_cnt++;
            if (dmem_addr != 32'd0 || dmem_op != 3'b010) ld_bad++;
        end
        if (wb_e) wb_e_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        dbg_raddr = idx;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && !done; i++) @(negedge clk);
        check(tag, {31'b0, done}, 32'd1);
    endtask

    initial begin
        int base, n0, w0;
        rst = 1'b1; rst_e = 1'b1; dcnt = 0;
        dbg_raddr = 5'd0; dbg_raddr_e = 5'd0; ld_delay = 3;
        for (int i = 0; i < 128; i++) imem[i] = 32'h00000013;
        imem[0]    = 32'h00500093;  // addi x1,x0,5
        imem[1]    = 32'hFF908113;  // addi x2,x1,-7
        imem[2]    = 32'h00202023;  // sw   x2,0(x0)
        imem[3]    = 32'h00002183;  // lw   x3,0(x0)
        imem[4]    = 32'h00000463;  // beq  x0,x0,+8
        imem[5]    = 32'h00100213;  // addi x4,x0,1 (skipped)
        imem[6]    = 32'h00001463;  // bne  x0,x0,+8
        imem[7]    = 32'h800002B7;  // lui  x5,0x80000
        imem[8]    = 32'h10028293;  // addi x5,x5,0x100
        imem[9]    = 32'h003280E7;  // jalr x1,x5,3
        imem[8'h40] = 32'hdead10cc; // halt at 0x80000100
        imem_e[0]  = 32'h00900093;  // addi x1,x0,9
        imem_e[1]  = 32'h00100893;  // addi x17,x0,1 -> illegal on RV32E
        imem_e[2]  = 32'h00000013;
        imem_e[3]  = 32'h00000013;

        repeat (3) @(negedge clk);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h80000000);
        check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst_wb", {31'b0, wb}, 32'd0);
        check("rst_done_trap", {30'b0, done, trap}, 32'd0);
        check("rst_dbg_pc", dbg_pc, 32'd0);
        rd_reg("rst_x1", 5'd1, 32'd0);

        @(negedge clk);
        rst = 1'b0; rst_e = 1'b0;
        wait_done("t1_done", 300);
        check("t1_trap", {31'b0, trap}, 32'd0);
        check("t1_wb_count", wb_pc_q.size(), 32'd9);
        for (int i = 0; i < 9; i++)
            if (i < wb_pc_q.size()) begin
                check($sformatf("t1_wb_pc%0d", i), wb_pc_q[i], exp_pc[i]);
                check($sformatf("t1_wb_cyc%0d", i), wb_cyc_q[i], exp_cyc[i]);
            end
        check("t2_ld_req_cycles", ld_req_cnt, 32'd4);
        check("t2_ld_unstable", ld_bad, 32'd0);
        check("t2_store_word", dmem[0], 32'hFFFFFFFE);
        rd_reg("t1_x2", 5'd2, 32'hFFFFFFFE);
        rd_reg("t2_x3", 5'd3, 32'hFFFFFFFE);
        rd_reg("t3_x4_skipped", 5'd4, 32'd0);
        rd_reg("t3_x5", 5'd5, 32'h80000100);
        rd_reg("t3_x1_link", 5'd1, 32'h80000028);
        rd_reg("t3_x0", 5'd0, 32'd0);
        check("t3_halt_pc", imem_addr, 32'h80000102);

        // RV32E instance: first add retires, then the x17 write traps.
        check("t5_e_done", {31'b0, done_e}, 32'd1);
        check("t5_e_trap", {31'b0, trap_e}, 32'd1);
        check("t5_e_wb_count", wb_e_cnt, 32'd1);
        check("t5_e_imem_req", {31'b0, imem_req_e}, 32'd0);
        dbg_raddr_e = 5'd1; #1;
        check("t5_e_x1", dbg_rdata_e, 32'd9);
        dbg_raddr_e = 5'd17; #1;
        check("t5_e_x17_oob", dbg_rdata_e, 32'd0);

        n0 = ireq_cnt; w0 = wb_pc_q.size();
        repeat (20) @(negedge clk);
        check("t4_no_imem_req", ireq_cnt - n0, 32'd0);
        check("t4_no_wb", wb_pc_q.size() - w0, 32'd0);
        check("t4_done_sticky", {31'b0, done}, 32'd1);
        rd_reg("t4_x2_kept", 5'd2, 32'hFFFFFFFE);

        // Reset asserted while a load is stalled in MEM.
        rst = 1'b1;
        @(negedge clk);
        ld_delay = 40; rst = 1'b0;
        for (int i = 0; i < 100 && !(dmem_req && !dmem_we); i++) @(negedge clk);
        check("t6_in_mem", {31'b0, dmem_req & ~dmem_we}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_dmem_req_async", {31'b0, dmem_req}, 32'd0);
        check("t6_imem_req_rst", {31'b0, imem_req}, 32'd0);
        rd_reg("t6_x2_cleared", 5'd2, 32'd0);
        @(negedge clk);
        ld_delay = 3; rst = 1'b0;
        #1;
        check("t6_refetch_req", {31'b0, imem_req}, 32'd1);
        check("t6_refetch_addr", imem_addr, 32'h80000000);
        base = wb_pc_q.size();
        wait_done("t6_done", 300);
        check("t6_wb_count", wb_pc_q.size() - base, 32'd9);
        if (wb_pc_q.size() > base) begin
            check("t6_first_pc", wb_pc_q[base], 32'h80000000);
            check("t6_first_cyc", wb_cyc_q[base], 32'd3);
        end
        rd_reg("t6_x3", 5'd3, 32'hFFFFFFFE);

        // All-zero word is illegal.
        rst = 1'b1;
        imem[0] = 32'h00000000;
        @(negedge clk);
        rst = 1'b0;
        base = wb_pc_q.size();
        wait_done("t5_zero_done", 50);
        check("t5_zero_trap", {31'b0, trap}, 32'd1);
        check("t5_zero_no_wb", wb_pc_q.size() - base, 32'd0);
        rd_reg("t5_zero_x1", 5'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
